// File: rtl/armleocpu_mem_1rwm_clr.sv
// Single-port RAM with per-lane write mask, selectable read-during-write result
// and a clear sequencer that fills every word with CLEAR_VALUE after reset or on request.
module armleocpu_mem_1rwm_clr #(
  parameter int unsigned ELEMENTS_W = 7,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GRANULARITY = 8,
  parameter int unsigned RDW_MODE = 0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear_req,
  output logic                              ready,
  input  logic [ELEMENTS_W-1:0]             address,
  input  logic                              read,
  output logic [WIDTH-1:0]                  readdata,
  output logic                              readdata_valid,
  input  logic                              write,
  input  logic [(WIDTH/GRANULARITY)-1:0]    writemask,
  input  logic [WIDTH-1:0]                  writedata
);

  localparam int unsigned ELEMENTS = 2 ** ELEMENTS_W;
  localparam int unsigned LANES = WIDTH / GRANULARITY;

  typedef enum logic {
    STATE_CLEAR,
    STATE_READY
  } state_t;

  state_t                  state;
  logic [ELEMENTS_W-1:0]   counter;
  logic [WIDTH-1:0]        storage [ELEMENTS];

  logic [WIDTH-1:0]        old_word_c;
  logic [WIDTH-1:0]        merged_word_c;
  logic                    accept_c;

  assign accept_c = (state == STATE_READY) && !clear_req;

  // Word as it will look after this cycle's masked write
  always_comb begin
    old_word_c = storage[address];
    merged_word_c = old_word_c;
    for (int i = 0; i < LANES; i++) begin
      if (writemask[i]) begin
        merged_word_c[i*GRANULARITY +: GRANULARITY] = writedata[i*GRANULARITY +: GRANULARITY];
      end
    end
  end

  // Storage is never reset; the clear sequence gives it a known value
  always_ff @(posedge clk) begin
    if (state == STATE_CLEAR) begin
      storage[counter] <= CLEAR_VALUE;
    end else if (accept_c && write) begin
      for (int i = 0; i < LANES; i++) begin
        if (writemask[i]) begin
          storage[address][i*GRANULARITY +: GRANULARITY] <= writedata[i*GRANULARITY +: GRANULARITY];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= STATE_CLEAR;
      counter        <= '0;
      ready          <= 1'b0;
      readdata       <= '0;
      readdata_valid <= 1'b0;
    end else begin
      case (state)
        STATE_CLEAR: begin
          readdata_valid <= 1'b0;
          counter        <= counter + ELEMENTS_W'(1);
          if (counter == '1) begin
            state <= STATE_READY;
            ready <= 1'b1;
          end
        end
        STATE_READY: begin
          if (clear_req) begin
            state          <= STATE_CLEAR;
            counter        <= '0;
            ready          <= 1'b0;
            readdata_valid <= 1'b0;
          end else begin
            readdata_valid <= read;
            if (read) begin
              readdata <= ((RDW_MODE == 1) && write) ? merged_word_c : old_word_c;
            end
          end
        end
        default: begin
          state <= STATE_CLEAR;
          counter <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/armleocpu_mem_1rwm_clr.md
# armleocpu_mem_1rwm_clr

Single-port synchronous RAM with per-lane write mask, a selectable read-during-write mode and a built-in clear sequencer. After reset, or on request, it fills every word with a fixed value, then serves one read and/or write per cycle with registered read data. It is the storage primitive for cache data/tag arrays and TLB banks that must come out of reset or flush in a known state.

## Interface
- ELEMENTS_W, 7: address width; depth ELEMENTS = 2**ELEMENTS_W.
- WIDTH, 32: word width in bits.
- GRANULARITY, 8: bits per write lane; WIDTH must be a multiple of it; LANES = WIDTH/GRANULARITY.
- RDW_MODE, 0: same-cycle read+write. 0 = read returns old word; 1 = read returns merged new word.
- CLEAR_VALUE, {WIDTH{1'b0}}: word written to every address during clear.

- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clear_req  input  1  start a full clear sequence.
- ready  output  1  high when read/write requests are accepted.
- address  input  ELEMENTS_W  word address for read and write.
- read  input  1  read request.
- readdata  output  WIDTH  registered read result.
- readdata_valid  output  1  high for one cycle after an accepted read.
- write  input  1  write request.
- writemask  input  LANES  per-lane write enable; lane i covers bits [i*GRANULARITY +: GRANULARITY].
- writedata  input  WIDTH  write data.

## Operation
- States: CLEAR, READY. Clear counter: ELEMENTS_W bits.
- Reset (rst=1): state=CLEAR, counter=0, ready=0, readdata=0, readdata_valid=0. Storage array is not reset.
- CLEAR: each edge writes CLEAR_VALUE to storage[counter], all lanes, and increments counter. On the edge that writes address ELEMENTS-1 (counter all ones), state becomes READY and counter wraps to 0. read/write/writemask are ignored. clear_req is ignored and does not restart the sequence. readdata holds its value. readdata_valid=0.
- READY: ready=1.
  - write=1: for each lane with writemask[i]=1, storage[address] lane i <= writedata lane i. Other lanes are unchanged. write with writemask=0 is a no-op.
  - read=1: readdata <= storage[address] and readdata_valid <= 1. When write is also 1, RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the merged word: masked lanes from writedata, other lanes old.
  - read=0: readdata holds and readdata_valid <= 0.
- clear_req=1 in READY has priority. That edge performs no write and no read, sets state=CLEAR, counter=0, readdata_valid=0. The clear's first write happens on the following edge.
- Requests presented while ready=0 are dropped, not queued. The master must sample ready before driving requests.

## Timing
- Read latency 1: an accepted read at edge N makes readdata and readdata_valid visible after edge N.
- Write latency 1: a read of the same address on the edge after a write sees the new data.
- Clear duration is exactly ELEMENTS edges. ready rises after the ELEMENTS-th edge following rst deassertion or following the clear_req edge.
- ready is a registered output, derived from state only. It has no combinational path from inputs.
- rst asserted mid-clear or mid-access: outputs go to their reset values immediately. The clear restarts at address 0 after deassertion. Words already written keep their values.
- Counter wrap is fully defined; no out-of-range address exists.

## Test plan
Use ELEMENTS_W=3, WIDTH=32, GRANULARITY=8 unless stated otherwise.
- Reset then idle: ready=0 for exactly 8 edges, then 1. Reading each address 0..7 returns 0x00000000 with readdata_valid pulsing one cycle per read.
- Masked write: write 0xAABBCCDD, mask 4'b1111, address 5. Then write 0x11223344, mask 4'b0101. Read address 5 -> 0xAA22CC44.
- Read-during-write, address 2 holding 0x0: write 0xFFFFFFFF, mask 4'b0011, with read=1. RDW_MODE=0 -> readdata 0x00000000; RDW_MODE=1 -> readdata 0x0000FFFF. A following read returns 0x0000FFFF in both modes.
- clear_req with simultaneous write of 0x12345678 to address 1: the write is dropped and ready=0 for 8 edges. With CLEAR_VALUE=0xDEADBEEF, all addresses then read 0xDEADBEEF.
- Requests during CLEAR: write 0x5 to address 3 while ready=0, and pulse clear_req mid-clear. Clear still ends after 8 edges total, and address 3 reads CLEAR_VALUE.
- Reset mid-clear: assert rst after 4 clear edges. readdata=0, ready=0 immediately. After release, ready rises after 8 edges.
